btn_repeat: RTL and testbench
=============================

# btn_repeat

Per-button press-event generator with delayed auto-repeat. Sits directly downstream of the button debounce filter and turns its clean, synchronised button levels into single-cycle key events for the game controller. Events come from three sources:
- the press edge;
- a repeat train that starts once a button has been held for a programmable delay;
- the release edge.

Auto-repeat is enabled per button, so move keys repeat and rotate/drop keys do not.

## Interface
- PIN_NUM, 3, number of buttons.
- DELAY_CYCLES, 12_000_000, cycles from the press event to the first repeat event; must be ≥ 2.
- REPEAT_CYCLES, 3_000_000, cycles between consecutive repeat events; must be ≥ 1.
- REPEAT_MASK, {PIN_NUM{1'b1}}, bit i = 1 enables auto-repeat on button i.
- CNT_W, 24, counter width; must satisfy 2^CNT_W > max(DELAY_CYCLES, REPEAT_CYCLES).
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- pin_in  in  PIN_NUM  debounced, already-synchronised button levels (1 = pressed).
- key_evt  out  PIN_NUM  one-cycle pulse per press or repeat event.
- key_rel  out  PIN_NUM  one-cycle pulse on release.
- key_held  out  PIN_NUM  registered copy of pin_in.

## Operation
- Each button has an independent channel: a previous-level register, a CNT_W-bit down-counter and a 2-bit state machine. Channels share nothing.
- States:
  - IDLE: button released.
  - DELAY: pressed, waiting for the first repeat.
  - REPEAT: auto-repeating.
  - HOLD: pressed, repeat disabled.
- IDLE → press edge (pin_in=1, prev=0):
  - pulse key_evt.
  - If the REPEAT_MASK bit is set: load cnt = DELAY_CYCLES-1 and go to DELAY.
  - Otherwise go to HOLD.
- DELAY, pin_in=1, cnt≠0: cnt decrements.
- DELAY, pin_in=1, cnt=0: pulse key_evt, load cnt = REPEAT_CYCLES-1, go to REPEAT.
- REPEAT, pin_in=1, cnt≠0: cnt decrements.
- REPEAT, pin_in=1, cnt=0: pulse key_evt and reload REPEAT_CYCLES-1.
- Release (pin_in=0) in DELAY, REPEAT or HOLD:
  - pulse key_rel, clear cnt, go to IDLE.
  - key_evt is never asserted in the release cycle, even if cnt=0 at that moment. Release wins.
- With REPEAT_CYCLES=1, key_evt stays high every cycle while in REPEAT.
- key_evt and key_rel are never high together on the same bit.
- Reset:
  - All states go to IDLE, cnt to 0, outputs to 0.
  - prev is forced to 1. A button held through reset therefore produces no press event; it must be released (no key_rel is emitted for this first release from IDLE) and then pressed again.
- Asserting reset mid-repeat aborts the train immediately. No further pulses occur until a fresh press edge after reset is deasserted.
- The counter never wraps. It is only decremented while nonzero, and only in DELAY or REPEAT.

## Timing
- All outputs are registered.
- Latency:
  - pin_in sampled high at edge t with prev=0: key_evt is high for exactly the cycle following edge t.
  - key_rel and key_held have the same one-cycle latency.
- The first repeat pulse comes exactly DELAY_CYCLES cycles after the press pulse.
- Each subsequent repeat pulse comes exactly REPEAT_CYCLES cycles after the previous one.
- Reset values: key_evt=0, key_rel=0, key_held=0.
- Outputs are 0 in the cycle after any edge where reset=1.
- No handshake. The consumer must sample key_evt every cycle.

## Test plan
All scenarios use PIN_NUM=3, DELAY_CYCLES=10, REPEAT_CYCLES=4, REPEAT_MASK=3'b011.
- Single press on bit 0, held 30 cycles, then released:
  - key_evt[0] pulses at cycles 1, 11, 15, 19, 23, 27 relative to the press edge.
  - key_rel[0] pulses once, one cycle after the release.
  - No other bits toggle.
- Press bit 2 (repeat masked), held 30 cycles:
  - exactly one key_evt[2] pulse, then key_rel[2] on release.
  - key_held[2]=1 throughout the hold.
- Press bit 0, release at cycle 10 (the cycle its counter would hit 0):
  - no repeat pulse.
  - key_rel[0] pulses.
  - A re-press 3 cycles later gives a fresh press pulse and a full 10-cycle delay.
- Hold pin_in=3'b111 through reset, deassert reset, keep holding 20 cycles:
  - no key_evt and no key_rel.
  - Release, then re-press bit 1: key_evt[1] pulses one cycle after the press edge.
- Assert reset for 1 cycle at cycle 17 during a bit 0 repeat train:
  - all outputs are 0 the next cycle.
  - No further key_evt[0] while the button stays held.
- Press bits 0 and 1 staggered by 2 cycles:
  - independent pulse trains, offset by exactly 2 cycles.

Source files
------------

// File: rtl/btn_repeat.sv
// ---------------------------------------------------------------------------
// btn_repeat
//
// Per-button press-event generator with delayed auto-repeat. Takes clean,
// synchronised button levels from the debounce filter and produces
// single-cycle key events for the game controller.
//
// Each button has its own channel: a previous-level register, a down-counter
// and a four-state machine (IDLE / DELAY / REPEAT / HOLD). Channels share
// nothing.
//
// Parameters
//   PIN_NUM        number of buttons
//   DELAY_CYCLES   cycles from the press event to the first repeat (>= 2)
//   REPEAT_CYCLES  cycles between consecutive repeat events (>= 1)
//   REPEAT_MASK    bit i = 1 enables auto-repeat on button i
//   CNT_W          counter width, 2^CNT_W > max(DELAY_CYCLES, REPEAT_CYCLES)
//
// Ports
//   clk       system clock, the only clock
//   reset     synchronous, active-high reset
//   pin_in    debounced button levels (1 = pressed)
//   key_evt   one-cycle pulse per press or repeat event (registered)
//   key_rel   one-cycle pulse on release (registered)
//   key_held  registered copy of pin_in
// ---------------------------------------------------------------------------
module btn_repeat #(
    parameter int                 PIN_NUM       = 3,
    parameter int                 DELAY_CYCLES  = 12_000_000,
    parameter int                 REPEAT_CYCLES = 3_000_000,
    parameter logic [PIN_NUM-1:0] REPEAT_MASK   = {PIN_NUM{1'b1}},
    parameter int                 CNT_W         = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PIN_NUM-1:0] pin_in,
    output logic [PIN_NUM-1:0] key_evt,
    output logic [PIN_NUM-1:0] key_rel,
    output logic [PIN_NUM-1:0] key_held
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,  // released
        DELAY  = 2'd1,  // pressed, waiting for the first repeat
        REPEAT = 2'd2,  // auto-repeating
        HOLD   = 2'd3   // pressed, repeat disabled for this button
    } state_t;

    // Counter loads: a value of N-1 makes the next event land exactly N
    // cycles after the current one, because the event fires on cnt == 0.
    localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_CYCLES - 1);

    for (genvar i = 0; i < PIN_NUM; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q,   cnt_d;
        logic             prev_q;
        logic             evt_q,   evt_d;
        logic             rel_q,   rel_d;
        logic             held_q;

        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the values from before the edge regardless of
        // statement order.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                // prev is forced high so a button held through reset must be
                // released and pressed again before it produces an event.
                prev_q  <= 1'b1;
                evt_q   <= 1'b0;
                rel_q   <= 1'b0;
                held_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                prev_q  <= pin_in[i];
                evt_q   <= evt_d;
                rel_q   <= rel_d;
                held_q  <= pin_in[i];
            end
        end

        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            evt_d   = 1'b0;
            rel_d   = 1'b0;

            unique case (state_q)
                IDLE: begin
                    // Only a genuine rising edge counts; a release seen here
                    // (e.g. the first release after reset) is silent.
                    if (pin_in[i] && !prev_q) begin
                        evt_d = 1'b1;
                        if (REPEAT_MASK[i]) begin
                            cnt_d   = DELAY_LOAD;
                            state_d = DELAY;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end

                DELAY, REPEAT: begin
                    // Release is checked first so it wins over a repeat
                    // event falling due in the same cycle.
                    if (!pin_in[i]) begin
                        rel_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        evt_d   = 1'b1;
                        cnt_d   = REPEAT_LOAD;
                        state_d = REPEAT;
                    end
                end

                HOLD: begin
                    if (!pin_in[i]) begin
                        rel_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        assign key_evt[i]  = evt_q;
        assign key_rel[i]  = rel_q;
        assign key_held[i] = held_q;
    end

endmodule

// File: tb/tb_btn_repeat.sv
// ---------------------------------------------------------------------------
// tb_btn_repeat
//
// Self-checking bench for btn_repeat with PIN_NUM=3, DELAY_CYCLES=10,
// REPEAT_CYCLES=4, REPEAT_MASK=3'b011. Directed scenarios are followed by a
// randomised phase; all outputs are compared every cycle against a model
// that derives expected events from the press time of each button.
// ---------------------------------------------------------------------------
module tb_btn_repeat;

    localparam int         PIN_NUM = 3;
    localparam int         D       = 10;
    localparam int         R       = 4;
    localparam logic [2:0] MASK    = 3'b011;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [PIN_NUM-1:0] pin_in = '0;
    logic [PIN_NUM-1:0] key_evt;
    logic [PIN_NUM-1:0] key_rel;
    logic [PIN_NUM-1:0] key_held;

    btn_repeat #(
        .PIN_NUM       (PIN_NUM),
        .DELAY_CYCLES  (D),
        .REPEAT_CYCLES (R),
        .REPEAT_MASK   (MASK),
        .CNT_W         (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pin_in   (pin_in),
        .key_evt  (key_evt),
        .key_rel  (key_rel),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a button is "active" from its press edge until its
    // release; events are a function of the age since that press edge.
    bit         active [PIN_NUM];
    int         press  [PIN_NUM];
    bit         last   [PIN_NUM];
    logic [2:0] exp_evt, exp_rel, exp_held;

    int evt0_log [$];

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [2:0] p, input logic r);
        for (int b = 0; b < PIN_NUM; b++) begin
            int age;
            exp_evt[b] = 1'b0;
            exp_rel[b] = 1'b0;
            if (r) begin
                exp_held[b] = 1'b0;
                active[b]   = 1'b0;
                last[b]     = 1'b1;
            end else begin
                exp_held[b] = p[b];
                if (!active[b]) begin
                    if (p[b] && !last[b]) begin
                        active[b]  = 1'b1;
                        press[b]   = cyc;
                        exp_evt[b] = 1'b1;
                    end
                end else if (!p[b]) begin
                    exp_rel[b] = 1'b1;
                    active[b]  = 1'b0;
                end else if (MASK[b]) begin
                    age = cyc - press[b];
                    if (age >= D && ((age - D) % R) == 0)
                        exp_evt[b] = 1'b1;
                end
                last[b] = p[b];
            end
        end
    endtask

    // One clock cycle: apply inputs, let the edge happen, check #1 later.
    task automatic step(input logic [2:0] p, input logic r);
        pin_in = p;
        reset  = r;
        @(posedge clk);
        cyc++;
        model(p, r);
        #1;
        chk("key_evt",  key_evt,  exp_evt);
        chk("key_rel",  key_rel,  exp_rel);
        chk("key_held", key_held, exp_held);
        chk("evt_rel_exclusive", key_evt & key_rel, 3'b000);
        if (key_evt[0]) evt0_log.push_back(cyc);
    endtask

    task automatic steps(input int n, input logic [2:0] p, input logic r);
        for (int k = 0; k < n; k++) step(p, r);
    endtask

    initial begin
        int         press_edge;
        int         exp_off [6];
        logic [2:0] rp;

        exp_off = '{1, 11, 15, 19, 23, 27};
        for (int b = 0; b < PIN_NUM; b++) begin
            active[b] = 1'b0;
            press[b]  = 0;
            last[b]   = 1'b1;
        end

        // Reset with buttons released
        steps(2, 3'b000, 1'b1);
        steps(3, 3'b000, 1'b0);

        // Scenario 1: bit 0 held 30 cycles, then released
        evt0_log.delete();
        press_edge = cyc + 1;
        steps(30, 3'b001, 1'b0);
        steps(4,  3'b000, 1'b0);
        chk_int("bit0_pulse_count", evt0_log.size(), 6);
        for (int k = 0; k < 6 && k < evt0_log.size(); k++)
            chk_int("bit0_pulse_offset", evt0_log[k] - press_edge + 1, exp_off[k]);

        // Scenario 2: bit 2 (repeat masked) held 30 cycles
        steps(30, 3'b100, 1'b0);
        steps(3,  3'b000, 1'b0);

        // Scenario 3: release exactly when the delay would expire, re-press
        steps(10, 3'b001, 1'b0);
        steps(3,  3'b000, 1'b0);
        steps(16, 3'b001, 1'b0);
        steps(3,  3'b000, 1'b0);

        // Scenario 4: all held through reset, no events until re-pressed
        steps(2,  3'b111, 1'b1);
        steps(20, 3'b111, 1'b0);
        steps(3,  3'b000, 1'b0);
        steps(5,  3'b010, 1'b0);
        steps(2,  3'b000, 1'b0);

        // Scenario 5: one-cycle reset mid repeat train on bit 0
        steps(16, 3'b001, 1'b0);
        steps(1,  3'b001, 1'b1);
        steps(20, 3'b001, 1'b0);
        steps(3,  3'b000, 1'b0);

        // Scenario 6: bits 0 and 1 staggered by 2 cycles
        steps(2,  3'b001, 1'b0);
        steps(25, 3'b011, 1'b0);
        steps(2,  3'b010, 1'b0);
        steps(3,  3'b000, 1'b0);

        // Randomised phase: slow toggling so repeat trains get exercised
        rp = 3'b000;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < PIN_NUM; b++)
                if ($urandom_range(0, 15) == 0) rp[b] = ~rp[b];
            step(rp, ($urandom_range(0, 299) == 0));
        end
        steps(3, 3'b000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
